// File: rtl/cond_branch_pc.sv
// Program counter with conditional jump, one-cycle flush bubble and sticky halt.
// Define COND_BRANCH_PC_STATS_EN to build the saturating taken-jump counter.
module cond_branch_pc #(
  parameter int unsigned UUID = 0,
  parameter string       NAME = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [2:0] cond,
  input  logic [7:0] value,
  input  logic [7:0] target,
  input  logic       stall,
  input  logic       halt_req,
  output logic [7:0] pc,
  output logic       flush,
  output logic       halted,
  output logic [7:0] taken_count
);

  typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic       neg, zero, base_true, cond_true, jump;

  // No child instances exist, so the identifiers have nowhere to go.
  logic unused_params;
  assign unused_params = (^UUID) ^ (NAME != "");

  // Codes 4-7 are the inverses of codes 0-3 (code 4 = not never = always).
  always_comb begin
    neg  = value[7];
    zero = (value == 8'h00);
    unique case (cond[1:0])
      2'd0:    base_true = 1'b0;
      2'd1:    base_true = zero;
      2'd2:    base_true = neg;
      default: base_true = neg | zero;
    endcase
    cond_true = base_true ^ cond[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    jump    = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!stall) begin
          if (halt_req) begin
            state_d = StHalt;
          end else if (valid && cond_true) begin
            jump    = 1'b1;
            pc_d    = target;
            state_d = StFlush;
          end else begin
            pc_d = pc_q + 8'd1;
          end
        end
      end
      StFlush: state_d = StRun;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    pc     = pc_q;
    flush  = (state_q == StFlush);
    halted = (state_q == StHalt);
  end

`ifdef COND_BRANCH_PC_STATS_EN
  logic [7:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'h00;
    end else if (jump && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign taken_count = count_q;
`else
  logic unused_jump;
  assign unused_jump = jump;
  assign taken_count = 8'h00;
`endif

endmodule
